// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MUL  = 2'b00,   // low half of product
        MULH = 2'b01,   // high half of product
        DIVU = 2'b10,   // quotient
        REMU = 2'b11    // remainder
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } muldiv_state_t;

    // Divide-family operations use the restoring-division step.
    function automatic logic is_div(input muldiv_op_t op);
        return (op == DIVU) || (op == REMU);
    endfunction

    // MULH and REMU return the upper working register; MUL and DIVU the lower.
    function automatic logic sel_high(input muldiv_op_t op);
        return (op == MULH) || (op == REMU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// hi/lo hold the product accumulator (MUL) or remainder/quotient (DIV).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int width = 16
) (
    input  muldiv_op_t         op,
    input  logic [width-1:0]   hi,
    input  logic [width-1:0]   lo,
    input  logic [width-1:0]   operand,
    output logic [width-1:0]   hi_next,
    output logic [width-1:0]   lo_next
);

    logic [width:0] sum;
    logic [width:0] trial;

    // Compute both candidate updates and select by operation family.
    always_comb begin
        // Multiply: add multiplicand into high half when multiplier LSB is set;
        // the carry is kept as bit width and shifted back into the accumulator.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(width+1){1'b0}});
        // Divide: shift dividend MSB into the width+1-bit partial remainder,
        // then trial-subtract the divisor; bit width of the result is the sign.
        trial   = {hi, lo[width-1]} - {1'b0, operand};
        hi_next = hi;
        lo_next = lo;
        if (is_div(op)) begin
            if (trial[width]) begin
                hi_next = {hi[width-2:0], lo[width-1]};
                lo_next = {lo[width-2:0], 1'b0};
            end else begin
                hi_next = trial[width-1:0];
                lo_next = {lo[width-2:0], 1'b1};
            end
        end else begin
            hi_next = sum[width:1];
            lo_next = {sum[0], lo[width-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit, one result bit per cycle.
// Handshake: start is a request sampled only while busy=0 (IDLE); a request
// seen in any other state is dropped, never queued. Completion is signalled by
// a registered one-cycle done strobe with result valid in that same cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int width = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [width-1:0]   result,
    output muldiv_state_t      state_dbg
);

    localparam int cw = (width > 2) ? $clog2(width) : 1;

    muldiv_state_t     state;
    muldiv_state_t     state_next;
    logic [cw-1:0]     cnt;
    logic              last;
    muldiv_op_t        op_r;
    logic [width-1:0]  operand;
    logic [width-1:0]  hi;
    logic [width-1:0]  lo;
    logic [width-1:0]  hi_next;
    logic [width-1:0]  lo_next;

    assign last = (cnt == cw'(width - 1));

    muldiv_step #(.width(width)) u_step (
        .op      (op_r),
        .hi      (hi),
        .lo      (lo),
        .operand (operand),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: IDLE -> BUSY on start, BUSY for width cycles, DONE for one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        state_dbg = state;
    end

    // Datapath: latch operands on acceptance, iterate in BUSY, capture result on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r    <= MUL;
            operand <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r    <= muldiv_op_t'(op);
                        operand <= is_div(muldiv_op_t'(op)) ? b : a;
                        lo      <= is_div(muldiv_op_t'(op)) ? a : b;
                        hi      <= '0;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt + cw'(1);
                    if (last) result <= sel_high(op_r) ? hi_next : lo_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations
// compared against a plain-arithmetic reference.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    muldiv_state_t state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_unit #(.width(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .state_dbg (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned arithmetic straight from the operation definitions.
    function automatic logic [W-1:0] ref_result(input logic [1:0] o,
                                                 input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (y == 0) ? {W{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left just after a falling edge. Issues one operation, waits
    // for done with a bounded budget, and checks latency, result and hand-back.
    // With noise set, start is pulsed with DIVU in cycles 3 and 16 and a/b are
    // scrambled every busy cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp, input bit noise);
        int lat;
        int busy_low;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        lat = 0;
        busy_low = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_low++;
            if (noise) begin
                start = (lat == 3);
                op    = 2'b10;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (noise) begin
            start = 1'b1;
            op    = 2'b10;
        end
        check({tag, " latency"}, 32'(lat), 32'(W));
        check({tag, " busy_held"}, 32'(busy_low), 32'd0);
        check({tag, " result"}, 32'(result), 32'(exp));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, " done_once"}, 32'(done), 32'd0);
        check({tag, " idle_after"}, 32'(busy), 32'd0);
        check({tag, " result_held"}, 32'(result), 32'(exp));
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int dones;

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset state", 32'(state_dbg), 32'(IDLE));

        // Reset outranks a simultaneous start.
        reset = 1'b1; start = 1'b1; a = 16'd9; b = 16'd9;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("reset_vs_start busy", 32'(busy), 32'd0);

        // Directed cases.
        run_op("mul_small",  2'b00, 16'h0123, 16'h0045, 16'h4E6F, 1'b0);
        run_op("mulh_small", 2'b01, 16'h0123, 16'h0045, 16'h0000, 1'b0);
        run_op("mul_max",    2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
        run_op("mulh_max",   2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
        run_op("divu_1000",  2'b10, 16'd1000, 16'd7,    16'h008E, 1'b0);
        run_op("remu_1000",  2'b11, 16'd1000, 16'd7,    16'h0006, 1'b0);
        run_op("divu_zero",  2'b10, 16'h1234, 16'h0000, 16'hFFFF, 1'b0);
        run_op("remu_zero",  2'b11, 16'h1234, 16'h0000, 16'h1234, 1'b0);

        // Ignored starts and operand changes while busy; then the very next
        // cycle (first IDLE) accepts a fresh request.
        run_op("mul_noise",  2'b00, 16'd3, 16'd5, 16'h000F, 1'b1);
        run_op("b2b_accept", 2'b11, 16'd50000, 16'd300, ref_result(2'b11, 16'd50000, 16'd300), 1'b0);

        // Abort a divide with reset in its eighth cycle.
        op = 2'b10; a = 16'hBEEF; b = 16'd13; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort state", 32'(state_dbg), 32'(IDLE));
        check("abort busy", 32'(busy), 32'd0);
        check("abort result", 32'(result), 32'd0);
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) dones++;
            @(posedge clk);
            @(negedge clk);
        end
        check("abort no_done", 32'(dones), 32'd0);
        run_op("mul_after_abort", 2'b00, 16'd2, 16'd2, 16'h0004, 1'b0);

        // Randomized operations, with divisor zero and extreme operands mixed in.
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 16'(1);
                2: ra = '1;
                3: rb = 16'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d", n), ro, ra, rb, ref_result(ro, ra, rb), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
